// File: rtl/ray_tri_streamer.sv
// ray_tri_streamer: pops one ray at a time from the input FIFO and, for each
// triangle in a runtime-selected window of triangle memory, pushes one
// 18-word intersection instruction {triangle[11:0], ray[5:0]} into the
// output FIFO.
// Optional feature: define STREAMER_RAY_ID_EN to build the ray tag counter
// that drives out_ray_id; without it out_ray_id is tied to zero.
module ray_tri_streamer #(
  parameter int D_BITS  = 32,
  parameter int M_BITS  = 12,
  parameter int MEM_LAT = 1,
  parameter int ID_BITS = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [M_BITS-1:0]          tri_base,
  input  logic [M_BITS:0]            tri_count,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  input  logic signed [6*D_BITS-1:0] ray_in,
  input  logic                       out_full,
  output logic                       out_wr_en,
  output logic signed [18*D_BITS-1:0] instruction_out,
  output logic                       out_last,
  output logic [ID_BITS-1:0]         out_ray_id,
  output logic [M_BITS-1:0]          mem_addr,
  input  logic signed [12*D_BITS-1:0] mem_data,
  output logic                       busy
);

  // Wait counter must hold the value MEM_LAT.
  localparam int W_BITS = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [6*D_BITS-1:0] ray_reg;
  logic [M_BITS:0]     lim;
  logic [M_BITS:0]     idx;
  logic [W_BITS-1:0]   wcnt;
  logic                accept;
  logic                capture;
  logic                write_go;
  logic                last_tri;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and per-cycle strobes decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    write_go   = 1'b0;
    // idx + 1 never overflows M_BITS+1 bits, and avoids lim-1 underflow.
    last_tri   = ((idx + 1'b1) == lim);
    unique case (state)
      IDLE: begin
        // in_rd_en high means a pop is still in flight; the FIFO head is stale.
        if (!in_empty && !in_rd_en) begin
          accept = 1'b1;
          if (tri_count != '0) state_next = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == '0) begin
          capture    = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (!out_full) begin
          write_go   = 1'b1;
          state_next = last_tri ? IDLE : WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: ray capture, triangle walk, memory wait and output pulses.
  always_ff @(posedge clock) begin
    // NOTE: the datapath registers are reset too; they are few and it keeps
    // every output at zero right after a reset, including a mid-ray one.
    if (reset) begin
      in_rd_en        <= 1'b0;
      out_wr_en       <= 1'b0;
      out_last        <= 1'b0;
      instruction_out <= '0;
      mem_addr        <= '0;
      ray_reg         <= '0;
      lim             <= '0;
      idx             <= '0;
      wcnt            <= '0;
    end else begin
      // Pop and push strobes are single-cycle pulses.
      in_rd_en  <= accept;
      out_wr_en <= write_go;
      out_last  <= write_go && last_tri;

      if (accept) begin
        ray_reg  <= ray_in;
        lim      <= tri_count;
        idx      <= '0;
        mem_addr <= tri_base;
        wcnt     <= W_BITS'(MEM_LAT);
      end

      if (state == WAIT) begin
        if (capture) instruction_out <= {mem_data, ray_reg};
        else         wcnt            <= wcnt - 1'b1;
      end

      if (write_go) begin
        idx <= idx + 1'b1;
        if (!last_tri) begin
          // Address wraps modulo 2^M_BITS by truncation.
          mem_addr <= mem_addr + 1'b1;
          wcnt     <= W_BITS'(MEM_LAT);
        end
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef STREAMER_RAY_ID_EN
  logic [ID_BITS-1:0] id_next;

  // Ray tag: each accepted ray (including empty windows) takes the next id.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_next    <= '0;
      out_ray_id <= '0;
    end else if (accept) begin
      out_ray_id <= id_next;
      id_next    <= id_next + 1'b1;
    end
  end
`else
  assign out_ray_id = '0;
`endif

endmodule

// File: doc/ray_tri_streamer.md
# ray_tri_streamer

Parametrised ray × triangle instruction generator. For each ray popped from the input FIFO, it reads a runtime-selectable window of triangles from triangle memory and emits one 18-word intersection instruction per triangle into the output FIFO. The instruction is the ray followed by the triangle. It sits between the ray-generation FIFO and the intersection pipeline, and adds the following:
- configurable memory latency
- runtime triangle base and count
- end-of-ray marking
- optional ray tagging

## Interface
Parameters:
- D_BITS, 32, width of one fixed-point word
- M_BITS, 12, triangle memory address width
- MEM_LAT, 1, triangle memory read latency in clocks (≥1)
- ID_BITS, 8, ray tag width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- tri_base  in  M_BITS  first triangle address; sampled at ray accept
- tri_count  in  M_BITS+1  triangles per ray (0..2^M_BITS); sampled at ray accept
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  input FIFO pop
- ray_in  in  6×D_BITS signed  ray (origin, direction); show-ahead, valid while !in_empty
- out_full  in  1  output FIFO full
- out_wr_en  out  1  output FIFO push
- instruction_out  out  18×D_BITS signed  [5:0] ray, [17:6] triangle
- out_last  out  1  qualifies out_wr_en; final triangle of the current ray
- out_ray_id  out  ID_BITS  ray tag
- mem_addr  out  M_BITS  triangle address
- mem_data  in  12×D_BITS signed  triangle read data
- busy  out  1  high when the state is not IDLE

## Operation
- States: IDLE, WAIT, EMIT.
- IDLE:
  - Acts only when !in_empty && !in_rd_en. This guard prevents double-accept while a pop is in flight.
  - Accept edge actions: in_rd_en<=1; ray_reg<=ray_in; lim<=tri_count; idx<=0; mem_addr<=tri_base; id<=id+1 (applied after the current ray's id is assigned).
  - tri_count==0: the ray is popped and discarded, there is no output, and the state remains IDLE. The ray id still advances.
  - Otherwise: wcnt<=MEM_LAT, and the state goes to WAIT.
- WAIT:
  - in_rd_en<=0; out_wr_en<=0; out_last<=0.
  - If wcnt==0: instruction_out[17:6]<=mem_data, instruction_out[5:0]<=ray_reg, go to EMIT.
  - Else wcnt<=wcnt-1.
- EMIT:
  - Holds while out_full is high; outputs are unchanged and no write occurs.
  - When !out_full: out_wr_en<=1; out_last<=(idx==lim-1); idx<=idx+1.
  - If last: the state goes to IDLE.
  - Else: mem_addr<=mem_addr+1 (modulo 2^M_BITS, so wrap is legal), wcnt<=MEM_LAT, and the state goes to WAIT.
- tri_base and tri_count changes mid-ray are ignored until the next accept.
- out_ray_id is the id of the ray being emitted. It wraps modulo 2^ID_BITS. The first ray after reset is 0.
- Reset (including mid-ray):
  - All outputs return to 0 at the reset edge: in_rd_en, out_wr_en, out_last, instruction_out, mem_addr, out_ray_id, busy. The state returns to IDLE and the id counter returns to 0.
  - A ray that was already popped is lost. Remaining triangles for that ray are not emitted.

## Timing
- mem_data is sampled on the (MEM_LAT+1)th rising edge after the edge that updated mem_addr.
- First write: out_wr_en rises MEM_LAT+2 edges after the accept edge.
- Steady state with out_full low: one write every MEM_LAT+2 cycles. Per ray: tri_count·(MEM_LAT+2)+1 cycles including the IDLE accept.
- out_wr_en is a 1-cycle pulse. instruction_out and out_last are stable while it is high. instruction_out holds until the next capture.
- in_rd_en is a 1-cycle pulse per accepted ray.
- out_full is sampled only in EMIT. A write is never issued on a cycle following an edge at which out_full was high.

## Configuration
- STREAMER_RAY_ID_EN defined: the id counter is built and out_ray_id carries the tag.
- Undefined: no counter is built and out_ray_id is tied to 0. All other behaviour is identical.

## Test plan
- MEM_LAT=1, tri_base=0, tri_count=3, mem[a]=a+1 in every word, one ray, out_full=0:
  - mem_addr 0,1,2.
  - 3 writes, 3 cycles apart; [17:6] equals 1,2,3; [5:0] equals the ray.
  - out_last only on the 3rd write; one in_rd_en pulse.
- Same setup, out_full forced high for 5 cycles while in EMIT on the 2nd triangle: no write during the stall; write on the first cycle after release; exactly 3 writes, none duplicated.
- tri_count=0, two rays queued: two in_rd_en pulses, zero out_wr_en; the next non-zero ray emits out_ray_id=2 (macro on).
- M_BITS=4, tri_base=14, tri_count=4: mem_addr 14,15,0,1; out_last on the 4th write.
- MEM_LAT=3, tri_count=2: writes 5 cycles apart, the first 5 edges after accept; data matches the addresses.
- Reset asserted 1 cycle after the 2nd of 4 writes:
  - All outputs are 0 at the reset edge; no further writes.
  - The next ray restarts at tri_base with out_ray_id=0.
